// File: rtl/tia_pos_pkg.sv
// Shared definitions for the object position counter and graphics scan sequencer.
// Holds the scale encodings, slot geometry and the pos-to-slot mapping.
package tia_pos_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'd0,
    SCALE_2X   = 2'd1,
    SCALE_4X   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_e;

  localparam int unsigned SLOT_COUNTS = 4;
  localparam int unsigned SCAN_BITS   = 8;

  function automatic int unsigned slot_of(input int unsigned p);
    return p / SLOT_COUNTS;
  endfunction

  // Last scan_sub value before scan_idx advances; the reserved code stretches like 4x.
  function automatic logic [1:0] sub_last_of(input scale_e s);
    logic [1:0] last;
    case (s)
      SCALE_1X: last = 2'd0;
      SCALE_2X: last = 2'd1;
      default:  last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/tia_graphics_scan_seq.sv
// Graphics scan sequencer: walks scan_idx 0..7, holding each bit for 1, 2 or 4 ticks.
// Shared by the player, missile and ball position counters.
module tia_graphics_scan_seq
  import tia_pos_pkg::*;
(
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       tick,
  input  logic       launch,
  input  logic       abort,
  input  logic [1:0] scale,
  output logic       scan_active,
  output logic [2:0] scan_idx
);

  localparam logic [2:0] LAST_IDX = 3'(SCAN_BITS - 1);

  logic [1:0] scan_sub;
  scale_e     scale_l;
  logic [1:0] sub_last;

  always_comb sub_last = sub_last_of(scale_l);

  // abort outranks launch so a position reset never lets a copy slip through.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      scan_active <= 1'b0;
      scan_idx    <= 3'd0;
      scan_sub    <= 2'd0;
      scale_l     <= SCALE_1X;
    end else if (tick) begin
      if (abort) begin
        scan_active <= 1'b0;
        scan_idx    <= 3'd0;
        scan_sub    <= 2'd0;
      end else if (launch) begin
        scan_active <= 1'b1;
        scan_idx    <= 3'd0;
        scan_sub    <= 2'd0;
        scale_l     <= scale_e'(scale);
      end else if (scan_active) begin
        if (scan_sub == sub_last) begin
          scan_sub <= 2'd0;
          if (scan_idx == LAST_IDX) begin
            scan_active <= 1'b0;
          end else begin
            scan_idx <= scan_idx + 3'd1;
          end
        end else begin
          scan_sub <= scan_sub + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tia_object_position_counter.sv
// Horizontal position counter: divides the pixel tick by 4 into a modulo-PERIOD count
// and launches a graphics scan at every copy slot enabled in copy_mask.
module tia_object_position_counter
  import tia_pos_pkg::*;
#(
  parameter  int PERIOD    = 40,
  parameter  int RESET_POS = 0,
  localparam int POS_W     = $clog2(PERIOD),
  localparam int NUM_SLOTS = PERIOD / 4,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_bar,
  input  logic                 pec_bar,
  input  logic                 motck,
  input  logic                 pre,
  input  logic [NUM_SLOTS-1:0] copy_mask,
  input  logic [1:0]           scale,
  output logic [POS_W-1:0]     pos,
  output logic                 wrap,
  output logic                 start_bar,
  output logic [IDX_W-1:0]     copy_idx,
  output logic                 scan_active,
  output logic [2:0]           scan_idx
);

  if ((PERIOD % 4) != 0 || PERIOD < 8 || PERIOD > 256) begin : g_bad_period
    $error("tia_object_position_counter: PERIOD must be a multiple of 4 in 8..256");
  end
  if (RESET_POS < 0 || RESET_POS >= PERIOD) begin : g_bad_reset_pos
    $error("tia_object_position_counter: RESET_POS must be below PERIOD");
  end

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD - 1);
  localparam logic [POS_W-1:0] RST_POS  = POS_W'(RESET_POS);

  logic             tick;
  logic [1:0]       phase;
  logic [POS_W-1:0] pos_n;
  logic [IDX_W-1:0] slot_n;
  logic             slot_hit;
  logic             advance;
  logic             launch;

  always_comb begin
    tick     = ~pec_bar | motck;
    pos_n    = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
    slot_n   = IDX_W'(slot_of(32'(pos_n)));
    slot_hit = (pos_n[1:0] == 2'b00) && copy_mask[slot_n];
    advance  = tick && !pre && (phase == 2'd3);
    launch   = advance && slot_hit;
  end

  // wrap and start_bar are single-cycle pulses and clear even on edges without a tick.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      pos       <= RST_POS;
      phase     <= 2'd0;
      wrap      <= 1'b0;
      start_bar <= 1'b1;
      copy_idx  <= '0;
    end else begin
      wrap      <= 1'b0;
      start_bar <= 1'b1;
      if (tick) begin
        if (pre) begin
          pos   <= RST_POS;
          phase <= 2'd0;
        end else begin
          phase <= phase + 2'd1;
          if (advance) begin
            pos  <= pos_n;
            wrap <= (pos_n == '0);
          end
          if (launch) begin
            start_bar <= 1'b0;
            copy_idx  <= slot_n;
          end
        end
      end
    end
  end

  tia_graphics_scan_seq u_scan_seq (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .tick       (tick),
    .launch     (launch),
    .abort      (pre),
    .scale      (scale),
    .scan_active(scan_active),
    .scan_idx   (scan_idx)
  );

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Randomized bench for tia_object_position_counter: a 40-count instance (RESET_POS 5)
// and an 8-count instance share stimulus and are compared against a tick-level model.
module tb_tia_object_position_counter;

  logic       clk;
  logic       reset_bar;
  logic       pec_bar;
  logic       motck;
  logic       pre;
  logic [9:0] copy_mask;
  logic [1:0] scale;

  logic [5:0] pos_a;
  logic       wrap_a, start_bar_a, scan_active_a;
  logic [3:0] copy_idx_a;
  logic [2:0] scan_idx_a;

  logic [2:0] pos_b;
  logic       wrap_b, start_bar_b, scan_active_b;
  logic [0:0] copy_idx_b;
  logic [2:0] scan_idx_b;

  int checks;
  int errors;

  tia_object_position_counter #(.PERIOD(40), .RESET_POS(5)) dut_a (
    .clk(clk), .reset_bar(reset_bar), .pec_bar(pec_bar), .motck(motck), .pre(pre),
    .copy_mask(copy_mask), .scale(scale),
    .pos(pos_a), .wrap(wrap_a), .start_bar(start_bar_a), .copy_idx(copy_idx_a),
    .scan_active(scan_active_a), .scan_idx(scan_idx_a)
  );

  tia_object_position_counter #(.PERIOD(8), .RESET_POS(0)) dut_b (
    .clk(clk), .reset_bar(reset_bar), .pec_bar(pec_bar), .motck(motck), .pre(pre),
    .copy_mask(copy_mask[1:0]), .scale(scale),
    .pos(pos_b), .wrap(wrap_b), .start_bar(start_bar_b), .copy_idx(copy_idx_b),
    .scan_active(scan_active_b), .scan_idx(scan_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: scan progress is kept as elapsed ticks since launch.
  typedef struct {
    int pos;
    int phase;
    int wrap;
    int start_bar;
    int copy_idx;
    int scan_on;
    int elapsed;
    int sh;
    int hold;
  } m_t;

  m_t ma, mb;

  function automatic m_t m_reset(int rpos);
    m_t r;
    r.pos = rpos; r.phase = 0; r.wrap = 0; r.start_bar = 1; r.copy_idx = 0;
    r.scan_on = 0; r.elapsed = 0; r.sh = 0; r.hold = 0;
    return r;
  endfunction

  function automatic m_t m_step(m_t s, int period, int rpos, logic rst_b, logic tk,
                                logic pre_i, logic [9:0] mask, logic [1:0] scl);
    m_t n;
    int pn;
    bit launch;
    if (!rst_b) return m_reset(rpos);
    n = s;
    n.wrap = 0;
    n.start_bar = 1;
    if (!tk) return n;
    if (pre_i) begin
      n.pos = rpos; n.phase = 0; n.scan_on = 0; n.hold = 0;
      return n;
    end
    launch = 1'b0;
    pn = 0;
    if (s.phase == 3) begin
      pn = (s.pos + 1) % period;
      n.pos = pn;
      n.wrap = (pn == 0) ? 1 : 0;
      launch = ((pn % 4) == 0) && mask[pn / 4];
    end
    n.phase = (s.phase + 1) % 4;
    if (launch) begin
      n.start_bar = 0;
      n.copy_idx = pn / 4;
      n.scan_on = 1;
      n.elapsed = 0;
      n.sh = (scl == 2'd0) ? 0 : (scl == 2'd1) ? 1 : 2;
    end else if (s.scan_on != 0) begin
      n.elapsed = s.elapsed + 1;
      if (n.elapsed == (8 << s.sh)) begin
        n.scan_on = 0;
        n.hold = 7;
      end
    end
    return n;
  endfunction

  function automatic int m_idx(m_t s);
    return (s.scan_on != 0) ? (s.elapsed >> s.sh) : s.hold;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check_val("a.pos",         int'(pos_a),         ma.pos);
    check_val("a.wrap",        int'(wrap_a),        ma.wrap);
    check_val("a.start_bar",   int'(start_bar_a),   ma.start_bar);
    check_val("a.copy_idx",    int'(copy_idx_a),    ma.copy_idx);
    check_val("a.scan_active", int'(scan_active_a), ma.scan_on);
    check_val("a.scan_idx",    int'(scan_idx_a),    m_idx(ma));
    check_val("b.pos",         int'(pos_b),         mb.pos);
    check_val("b.wrap",        int'(wrap_b),        mb.wrap);
    check_val("b.start_bar",   int'(start_bar_b),   mb.start_bar);
    check_val("b.copy_idx",    int'(copy_idx_b),    mb.copy_idx);
    check_val("b.scan_active", int'(scan_active_b), mb.scan_on);
    check_val("b.scan_idx",    int'(scan_idx_b),    m_idx(mb));
  endtask

  // Probabilities are per mille, drawn fresh on every cycle.
  task automatic run(input int cycles, input int p_idle, input int p_mot, input int p_pre,
                     input int p_mask, input int p_scale, input int p_rst);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      ma = m_step(ma, 40, 5, reset_bar, !pec_bar || motck, pre, copy_mask, scale);
      mb = m_step(mb, 8, 0, reset_bar, !pec_bar || motck, pre, copy_mask, scale);
      @(negedge clk);
      check_all();
      if (!reset_bar) reset_bar = 1'b1;
      pec_bar = ($urandom_range(0, 999) < p_idle);
      motck   = ($urandom_range(0, 999) < p_mot);
      pre     = ($urandom_range(0, 999) < p_pre);
      if ($urandom_range(0, 999) < p_mask)  copy_mask = 10'($urandom);
      if ($urandom_range(0, 999) < p_scale) scale = 2'($urandom);
      if ($urandom_range(0, 999) < p_rst) begin
        #2;
        reset_bar = 1'b0;
        #1;
        ma = m_reset(5);
        mb = m_reset(0);
        check_all();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_bar = 1'b0;
    pec_bar   = 1'b0;
    motck     = 1'b0;
    pre       = 1'b0;
    copy_mask = 10'b0000000001;
    scale     = 2'd0;
    ma = m_reset(5);
    mb = m_reset(0);
    repeat (2) @(negedge clk);
    check_all();

    run(400, 0, 0, 0, 0, 0, 0);
    copy_mask = 10'b0000010101;
    run(400, 0, 0, 0, 0, 0, 0);
    copy_mask = 10'b0000000001;
    scale = 2'd2;
    run(400, 0, 0, 0, 0, 20, 0);
    copy_mask = 10'b0000000101;
    run(200, 0, 0, 15, 0, 0, 0);
    run(600, 1000, 300, 0, 0, 0, 0);
    run(25, 1000, 0, 0, 0, 0, 0);
    run(2500, 200, 50, 10, 20, 20, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
